// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor for the five-stage RISC-V pipeline. A direct-mapped
//   BTB of 2-bit saturating counters is looked up with PCF. The prediction
//   follows the instruction through the D and E pipeline registers. In Execute it
//   is compared with the resolved outcome to raise MispredictE/PCCorrectE and to
//   train the table.
//
//   Optional feature: define BP_PERF_EN to add the BranchCount/MispredCount
//   performance counters; otherwise both outputs are tied to zero.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   PCF                         fetch PC
//   StallD, FlushD, FlushE      pipeline hazard controls for the prediction regs
//   PCE, BranchE, JumpE         Execute-stage PC and branch/jump qualifiers
//   PCSrcE, PCTargetE           resolved direction and target
//   PredTakenF, PredTargetF     fetch-stage prediction for PCF
//   MispredictE, PCCorrectE     fetch redirect request and corrected next PC
//   BranchCount, MispredCount   performance counters (zero without BP_PERF_EN)
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic [XLEN-1:0] PCE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  output logic            MispredictE,
  output logic [XLEN-1:0] PCCorrectE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];

  logic [IDXW-1:0] idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit_f, hit_e;

  logic            dreg_taken_q, dreg_taken_d;
  logic [XLEN-1:0] dreg_target_q, dreg_target_d;
  logic            ereg_taken_q, ereg_taken_d;
  logic [XLEN-1:0] ereg_target_q, ereg_target_d;

  logic            resolve_e;
  logic            ent_we;
  logic            valid_d;
  logic [TAGW-1:0] tag_d;
  logic [XLEN-1:0] tgt_d;
  logic [1:0]      ctr_d;

  // Fetch lookup
  assign idx_f       = PCF[IDXW+1:2];
  assign tag_f       = PCF[XLEN-1:IDXW+2];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? tgt_q[idx_f] : PCF + PC_INC;

  // D/E prediction registers: flush beats stall in D
  always_comb begin
    dreg_taken_d  = PredTakenF;
    dreg_target_d = PredTargetF;
    if (FlushD) begin
      dreg_taken_d  = 1'b0;
      dreg_target_d = '0;
    end else if (StallD) begin
      dreg_taken_d  = dreg_taken_q;
      dreg_target_d = dreg_target_q;
    end
    ereg_taken_d  = FlushE ? 1'b0 : dreg_taken_q;
    ereg_target_d = FlushE ? '0   : dreg_target_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dreg_taken_q  <= 1'b0;
      dreg_target_q <= '0;
      ereg_taken_q  <= 1'b0;
      ereg_target_q <= '0;
    end else begin
      dreg_taken_q  <= dreg_taken_d;
      dreg_target_q <= dreg_target_d;
      ereg_taken_q  <= ereg_taken_d;
      ereg_target_q <= ereg_target_d;
    end
  end

  // Execute-stage resolution
  assign resolve_e = BranchE || JumpE;
  assign idx_e     = PCE[IDXW+1:2];
  assign tag_e     = PCE[XLEN-1:IDXW+2];
  assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // A predicted-taken non-branch is an alias hit and must be redirected too
  assign MispredictE = resolve_e
                     ? ((PCSrcE != ereg_taken_q) ||
                        (PCSrcE && ereg_taken_q && (ereg_target_q != PCTargetE)))
                     : ereg_taken_q;
  assign PCCorrectE  = (resolve_e && PCSrcE) ? PCTargetE : PCE + PC_INC;

  // Next contents of the entry at PCE's index
  always_comb begin
    ent_we  = 1'b0;
    valid_d = valid_q[idx_e];
    tag_d   = tag_q[idx_e];
    tgt_d   = tgt_q[idx_e];
    ctr_d   = ctr_q[idx_e];
    if (resolve_e) begin
      if (hit_e) begin
        ent_we = 1'b1;
        if (PCSrcE) begin
          tgt_d = PCTargetE;
          if (ctr_q[idx_e] != 2'b11) ctr_d = ctr_q[idx_e] + 2'b01;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_d = ctr_q[idx_e] - 2'b01;
        end
      end else if (PCSrcE) begin
        ent_we  = 1'b1;
        valid_d = 1'b1;
        tag_d   = tag_e;
        tgt_d   = PCTargetE;
        ctr_d   = 2'b10;
      end
    end else if (ereg_taken_q) begin
      ent_we  = 1'b1;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ent_we) begin
      valid_q[idx_e] <= valid_d;
      tag_q[idx_e]   <= tag_d;
      tgt_q[idx_e]   <= tgt_d;
      ctr_q[idx_e]   <= ctr_d;
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q  + (resolve_e   ? 32'd1 : 32'd0);
    mispred_cnt_d = mispred_cnt_q + (MispredictE ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed-vector bench for branch_predictor (XLEN=32, ENTRIES=16). PCs 0x100
//   and 0x140 share index 0; the idle fetch PC 0x204 maps to index 1, which is
//   never allocated, so idle fetches always predict not-taken.
module tb_branch_predictor;

  localparam logic [31:0] IDLE = 32'h0000_0204;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallD, FlushD, FlushE;
  logic [31:0] PCE;
  logic        BranchE, JumpE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        MispredictE;
  logic [31:0] PCCorrectE;
  logic [31:0] BranchCount, MispredCount;

  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;
  int n_mis = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .PCF(PCF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCE(PCE), .BranchE(BranchE), .JumpE(JumpE), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .MispredictE(MispredictE), .PCCorrectE(PCCorrectE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational lookup of pc, then back to the idle fetch PC
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    PCF = pc;
    #1;
    check({tag, ".tk"}, {31'b0, PredTakenF}, {31'b0, exp_tk});
    check({tag, ".tgt"}, PredTargetF, exp_tgt);
    PCF = IDLE;
    #1;
  endtask

  // One Execute cycle with a resolving branch/jump
  task automatic resolve(input string tag, input logic [31:0] pce, input logic br,
                         input logic jmp, input logic tk, input logic [31:0] tgt,
                         input logic exp_mis, input logic [31:0] exp_corr);
    PCE = pce; BranchE = br; JumpE = jmp; PCSrcE = tk; PCTargetE = tgt;
    #1;
    check({tag, ".mis"}, {31'b0, MispredictE}, {31'b0, exp_mis});
    check({tag, ".corr"}, PCCorrectE, exp_corr);
    n_res++;
    if (exp_mis) n_mis++;
    tick();
    BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b0;
  endtask

  // Fetch pc, then one idle fetch, so its prediction sits in E
  task automatic flow(input logic [31:0] pc);
    PCF = pc;
    tick();
    PCF = IDLE;
    tick();
  endtask

  task automatic check_perf(input string tag);
`ifdef BP_PERF_EN
    check({tag, ".bcnt"}, BranchCount, 32'(n_res));
    check({tag, ".mcnt"}, MispredCount, 32'(n_mis));
`else
    check({tag, ".bcnt"}, BranchCount, 32'd0);
    check({tag, ".mcnt"}, MispredCount, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b0; PCF = IDLE; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    PCE = 32'h0; BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    tick(); tick();
    reset = 1'b1;
    #1;

    // Reset state
    check("rst.mis", {31'b0, MispredictE}, 32'd0);
    check("rst.corr", PCCorrectE, 32'h4);
    check("rst.bcnt", BranchCount, 32'd0);
    check("rst.mcnt", MispredCount, 32'd0);
    look("rst.look", 32'h100, 1'b0, 32'h104);

    // First taken resolution allocates; same-cycle lookup sees old contents
    PCE = 32'h100; BranchE = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80;
    #1;
    check("alloc.mis", {31'b0, MispredictE}, 32'd1);
    check("alloc.corr", PCCorrectE, 32'h80);
    look("alloc.nobypass", 32'h100, 1'b0, 32'h104);
    n_res++; n_mis++;
    tick();
    BranchE = 1'b0; PCSrcE = 1'b0;
    look("alloc.after", 32'h100, 1'b1, 32'h80);

    // Predicted taken flows to E, resolves not-taken: 10 -> 01 -> 00
    flow(32'h100);
    resolve("nt1", 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h104);
    look("nt1.look", 32'h100, 1'b0, 32'h104);
    resolve("nt2", 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    look("nt2.look", 32'h100, 1'b0, 32'h104);

    // Taken: 00 -> 01 -> 10 -> 11 -> 11
    resolve("t1", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    look("t1.look", 32'h100, 1'b0, 32'h104);
    resolve("t2", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    look("t2.look", 32'h100, 1'b1, 32'h80);
    resolve("t3", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    resolve("t4", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    // Not-taken: 11 -> 10 -> 01 -> 00 -> 00
    resolve("d1", 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    look("d1.look", 32'h100, 1'b1, 32'h80);
    resolve("d2", 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    look("d2.look", 32'h100, 1'b0, 32'h104);
    resolve("d3", 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    resolve("d4", 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    // One taken from 00 lands on 01, still not-taken
    resolve("u1", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    look("u1.look", 32'h100, 1'b0, 32'h104);
    resolve("u2", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);

    // Direction right, target wrong -> mispredict, target retrained
    flow(32'h100);
    resolve("tgtmis", 32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h90);
    look("tgtmis.look", 32'h100, 1'b1, 32'h90);
    flow(32'h100);
    resolve("tgtok", 32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0, 32'h90);

    // Tag alias: 0x140 replaces 0x100 at index 0
    resolve("alias", 32'h140, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300);
    look("alias.old", 32'h100, 1'b0, 32'h104);
    look("alias.new", 32'h140, 1'b1, 32'h300);

    // Predicted taken reaching E on a non-branch: mispredict and invalidate
    flow(32'h140);
    PCE = 32'h140;
    #1;
    check("nonbr.mis", {31'b0, MispredictE}, 32'd1);
    check("nonbr.corr", PCCorrectE, 32'h144);
    n_mis++;
    tick();
    look("nonbr.look", 32'h140, 1'b0, 32'h144);

    // Re-allocate, then FlushD+StallD clears D while FlushE drops D's prediction
    resolve("realloc", 32'h140, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300);
    PCF = 32'h140;
    tick();
    PCF = IDLE; FlushD = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    PCE = 32'h140;
    #1;
    check("flushe.mis", {31'b0, MispredictE}, 32'd0);
    tick();
    check("flushd.mis", {31'b0, MispredictE}, 32'd0);
    look("flush.entry", 32'h140, 1'b1, 32'h300);

    // StallD alone holds the prediction (FlushE keeps E clear meanwhile)
    PCF = 32'h140;
    tick();
    PCF = IDLE; StallD = 1'b1; FlushE = 1'b1;
    tick();
    StallD = 1'b0; FlushE = 1'b0;
    #1;
    check("stall.e0", {31'b0, MispredictE}, 32'd0);
    tick();
    resolve("stall.held", 32'h140, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h300);

    // PC+4 wraps at 2^32
    resolve("wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("wrap.look", 32'hFFFF_FFFC, 1'b0, 32'h0);

    check_perf("perf");

    // Reset with a predicted-taken instruction in E discards everything
    flow(32'h140);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    PCE = 32'h140;
    #1;
    check("rst2.mis", {31'b0, MispredictE}, 32'd0);
    look("rst2.look", 32'h140, 1'b0, 32'h144);
    check("rst2.bcnt", BranchCount, 32'd0);
    check("rst2.mcnt", MispredCount, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
